ab_sequence_driver: RTL and testbench
=====================================

// Module: ab_sequence_driver
// PURPOSE
//   Initiator side of the 2-input (a,b) 3-state FSM interface. Accepts a requested
//   target state on a valid/ready port, drives the a/b sequence that steers the
//   target FSM there, and keeps a cycle-accurate shadow of the target's state.
//   Compiled with MONITOR_EN, it also checks the target's y0/y1 outputs.
//   Sits between a test/control master and any s0/s1/s2 a/b machine.
// PARAMETERS
//   GAP_W     4  width of the inter-step gap counter
//   STEP_GAP  0  idle cycles (a=b=0) inserted between the two steps of a 2-step path; 0..2^GAP_W-1
// PORTS
//   clk        in   1  rising-edge clock
//   reset_n    in   1  asynchronous active-low reset
//   req_valid  in   1  target request valid
//   req_ready  out  1  driver can accept a request (IDLE only)
//   req_state  in   2  requested state: 00=s0, 01=s1, 10=s2, 11 illegal
//   a, b       out  1  registered drive to the target FSM
//   y0, y1     in   1  target outputs (Mealy y0, Moore y1); used only with MONITOR_EN
//   shadow     out  2  mirrored target state
//   done       out  1  1-cycle pulse: shadow reached the requested state
//   err        out  1  sticky error flag
//   err_clr    in   1  clears err and leaves ERR
// BEHAVIOUR
// - Reset (reset_n=0, any time, including mid-sequence):
//   - ctrl=IDLE, a=b=0, shadow=s0, done=0, err=0, gap counter=0.
//   - req_ready=1 from the first edge after release.
// - Shadow: updates every posedge from the currently driven a/b with the target equations:
//   - s0: a&b->s2, a&~b->s1, ~a->s0
//   - s1: a->s0, else s1
//   - s2: ->s0 unconditionally
//   - illegal 11 -> s0
//   - shadow_d is the next-shadow value.
// - Control FSM: IDLE, STEP1, GAP, STEP2, DONE, ERR.
//   - IDLE: a=b=0, req_ready=1. A handshake (req_valid&req_ready) latches tgt.
//   - Path planning uses shadow_d at the accept edge:
//     - equal -> DONE (no drive)
//     - s0->s1 {a,b}=10 (1 step); s0->s2 11 (1 step)
//     - s1->s0 10 (1 step); s1->s2 10 then 11
//     - s2->s0 00 (1 step); s2->s1 00 then 10
//   - STEP1 drives the step 1 a/b for exactly 1 cycle.
//     - 1-step path -> DONE.
//     - 2-step path -> GAP if STEP_GAP>0, else STEP2.
//   - GAP: a=b=0 for STEP_GAP cycles. The intermediate state is always s0, which holds under a=0.
//   - STEP2 drives the step 2 a/b for 1 cycle, then -> DONE.
//   - DONE: a=b=0 and done=1 for 1 cycle (shadow==tgt is guaranteed), then -> IDLE.
//   - Latency accept->done:
//     - same state: 1 cycle
//     - 1 step: 2 cycles
//     - 2 step: 3+STEP_GAP cycles
// - Illegal req_state=11:
//   - Accepted, then ctrl->ERR, err=1, no drive, no done.
// - ERR state:
//   - a=b=0, req_ready=0, done=0.
//   - err_clr=1 -> IDLE next cycle and err=0.
//   - err_clr is ignored outside ERR.
// - s2 requests: s2 is transient. done fires in the cycle shadow==s2; shadow returns to s0 on the next edge.
// - req_valid while busy: ignored (req_ready=0). The requester must hold req_valid/req_state until ready.
// CONFIGURATION
//   MONITOR_EN defined:
//     - Each cycle outside reset, compare y1 against (shadow==s0||shadow==s1)
//       and y0 against (shadow==s0 & a & b).
//     - Any mismatch -> ERR, err=1 on the next edge; a sequence in flight is abandoned (no done).
//   MONITOR_EN undefined:
//     - y0/y1 are ignored.
//     - err is raised only by illegal requests.
// TESTING
//   1 Reset: hold reset_n=0 mid-STEP1 -> a=b=0, shadow=00, done=0, err=0 asynchronously.
//   2 From s0 request 01 -> STEP1 drives a=1,b=0 for 1 cycle; shadow=01; done 2 cycles after accept.
//   3 From s1 request 10, STEP_GAP=2 -> drive 10, then 00,00, then 11; shadow 01->00->00->00->10;
//     done 5 cycles after accept.
//   4 From s1 request 01 -> done 1 cycle after accept, a=b=0 throughout.
//   5 Request 11 -> err=1, req_ready=0, no done; err_clr pulse -> err=0, req_ready=1 next cycle.
//   6 MONITOR_EN: in s1, force y1=0 -> err=1 next edge, a=b=0; without the macro, no err.

Source files
------------

// File: rtl/ab_sequence_driver_if.sv
// Request/drive bundle between a control master, the a/b sequence driver and the target FSM.
// The slave modport is the driver's view; the master modport is the requester/target side.
interface ab_sequence_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_state;
  logic       a;
  logic       b;
  logic       y0;
  logic       y1;
  logic [1:0] shadow;
  logic       done;
  logic       err;
  logic       err_clr;

  modport slave  (input  req_valid, req_state, y0, y1, err_clr,
                  output req_ready, a, b, shadow, done, err);
  modport master (output req_valid, req_state, y0, y1, err_clr,
                  input  req_ready, a, b, shadow, done, err);
endinterface

// File: rtl/ab_sequence_driver.sv
// Steers an s0/s1/s2 a/b target FSM to a requested state while shadowing its state.
// Define MONITOR_EN to cross-check the target's y0/y1 against the shadow.
module ab_sequence_driver #(
  parameter int GAP_W    = 4,
  parameter int STEP_GAP = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ab_sequence_driver_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, STEP1, GAP, STEP2, DONE, ERR} ctrl_e;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [GAP_W-1:0] GAP_LOAD = (STEP_GAP > 0) ? GAP_W'(STEP_GAP - 1) : '0;

  ctrl_e            state_q, state_d;
  logic [1:0]       shadow_q, shadow_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [1:0]       step1_q, step1_d;
  logic [1:0]       step2_q, step2_d;
  logic             two_step_q, two_step_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       ab_q, ab_d;
  logic             ready_q, done_q, err_q;
  logic             accept;
  logic             mon_err;

  assign bus.a         = ab_q[1];
  assign bus.b         = ab_q[0];
  assign bus.shadow    = shadow_q;
  assign bus.req_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  assign accept = bus.req_valid & ready_q;

  // Target transition equations, applied to whatever a/b is on the wires this cycle
  always_comb begin
    shadow_d = S0;
    case (shadow_q)
      S0:      shadow_d = ab_q[1] ? (ab_q[0] ? S2 : S1) : S0;
      S1:      shadow_d = ab_q[1] ? S0 : S1;
      default: shadow_d = S0;
    endcase
  end

`ifdef MONITOR_EN
  logic exp_y0, exp_y1;
  assign exp_y1  = (shadow_q == S0) || (shadow_q == S1);
  assign exp_y0  = (shadow_q == S0) & ab_q[1] & ab_q[0];
  assign mon_err = (bus.y1 != exp_y1) || (bus.y0 != exp_y0);
`else
  logic unused_y;
  assign unused_y = ^{bus.y0, bus.y1};
  assign mon_err  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    step1_d    = step1_q;
    step2_d    = step2_q;
    two_step_d = two_step_q;
    gap_d      = gap_q;
    case (state_q)
      IDLE: if (accept) begin
        tgt_d = bus.req_state;
        if (bus.req_state == 2'b11)          state_d = ERR;
        else if (bus.req_state == shadow_d)  state_d = DONE;
        else begin
          state_d    = STEP1;
          two_step_d = 1'b0;
          step2_d    = 2'b00;
          // Two-step paths always pass through s0, which holds while a=0
          case ({shadow_d, bus.req_state})
            {S0, S1}: step1_d = 2'b10;
            {S0, S2}: step1_d = 2'b11;
            {S1, S0}: step1_d = 2'b10;
            {S1, S2}: begin step1_d = 2'b10; step2_d = 2'b11; two_step_d = 1'b1; end
            {S2, S1}: begin step1_d = 2'b00; step2_d = 2'b10; two_step_d = 1'b1; end
            default:  step1_d = 2'b00;
          endcase
        end
      end
      STEP1: begin
        if (!two_step_q)       state_d = DONE;
        else if (STEP_GAP > 0) begin state_d = GAP; gap_d = GAP_LOAD; end
        else                   state_d = STEP2;
      end
      GAP: begin
        if (gap_q == '0) state_d = STEP2;
        else             gap_d   = gap_q - 1'b1;
      end
      STEP2:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     if (bus.err_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mon_err) state_d = ERR;
  end

  always_comb begin
    ab_d = 2'b00;
    case (state_d)
      STEP1:   ab_d = step1_d;
      STEP2:   ab_d = step2_q;
      default: ab_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shadow_q   <= S0;
      tgt_q      <= S0;
      step1_q    <= 2'b00;
      step2_q    <= 2'b00;
      two_step_q <= 1'b0;
      gap_q      <= '0;
      ab_q       <= 2'b00;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      tgt_q      <= tgt_d;
      step1_q    <= step1_d;
      step2_q    <= step2_d;
      two_step_q <= two_step_d;
      gap_q      <= gap_d;
      ab_q       <= ab_d;
      ready_q    <= (state_d == IDLE);
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_ab_sequence_driver.sv
// Directed bench for ab_sequence_driver with a behavioural s0/s1/s2 target and a done scoreboard.
module tb_ab_sequence_driver;
  localparam int STEP_GAP = 2;

  typedef struct {
    logic [1:0] st;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic force_y1_lo;
  logic [1:0] tst;
  int n_chk  = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [1:0] tr_ab[$];
  logic [1:0] tr_sh[$];

  always #5 clk = ~clk;

  ab_sequence_driver_if bus ();

  ab_sequence_driver #(.GAP_W(4), .STEP_GAP(STEP_GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural target FSM fed by the DUT's a/b
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tst <= 2'b00;
    else case (tst)
      2'b00:   tst <= bus.a ? (bus.b ? 2'b10 : 2'b01) : 2'b00;
      2'b01:   tst <= bus.a ? 2'b00 : 2'b01;
      default: tst <= 2'b00;
    endcase
  end
  assign bus.y1 = force_y1_lo ? 1'b0 : ((tst == 2'b00) || (tst == 2'b01));
  assign bus.y0 = (tst == 2'b00) & bus.a & bus.b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [1:0] st, input int lat);
    int   n;
    bit   got;
    exp_t e;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_state = st;
    @(negedge clk);
    bus.req_valid = 1'b0;
    sb.push_back('{st, lat});
    tr_ab.delete();
    tr_sh.delete();
    got = 1'b0;
    for (int c = 1; c <= 30 && !got; c++) begin
      tr_ab.push_back({bus.a, bus.b});
      tr_sh.push_back(bus.shadow);
      if (bus.done) begin
        e = sb.pop_front();
        chk("done_latency", c, e.lat);
        chk("done_shadow", bus.shadow, e.st);
        got = 1'b1;
      end else @(negedge clk);
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [1:0] exp_ab[5];
    logic [1:0] exp_sh[5];
    bit saw_done;
    reset_n         = 1'b0;
    force_y1_lo     = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_state   = 2'b00;
    bus.err_clr     = 1'b0;
    #2;
    chk("rst_ab",     {bus.a, bus.b}, 0);
    chk("rst_shadow", bus.shadow, 0);
    chk("rst_done",   bus.done, 0);
    chk("rst_err",    bus.err, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready, 1);

    // s0 -> s1, one step
    request(2'b01, 2);
    chk("s0s1_ab0", tr_ab[0], 2'b10);
    chk("s0s1_ab1", tr_ab[1], 2'b00);
    chk("s0s1_sh0", tr_sh[0], 2'b00);
    chk("s0s1_sh1", tr_sh[1], 2'b01);

    // s1 -> s1, no drive
    request(2'b01, 1);
    chk("s1s1_ab0", tr_ab[0], 2'b00);

    // s1 -> s2 through s0 with a two-cycle gap
    request(2'b10, 3 + STEP_GAP);
    exp_ab = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b00};
    exp_sh = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    for (int i = 0; i < 5; i++) begin
      if (i < tr_ab.size()) begin
        chk($sformatf("s1s2_ab%0d", i), tr_ab[i], exp_ab[i]);
        chk($sformatf("s1s2_sh%0d", i), tr_sh[i], exp_sh[i]);
      end else chk($sformatf("s1s2_short%0d", i), tr_ab.size(), 5);
    end
    @(negedge clk);
    chk("s2_transient", bus.shadow, 2'b00);

    // s0 -> s2 single step, then s0 -> s1 -> s0
    request(2'b10, 2);
    chk("s0s2_ab0", tr_ab[0], 2'b11);
    request(2'b01, 2);
    request(2'b00, 2);
    chk("s1s0_ab0", tr_ab[0], 2'b10);
    chk("s1s0_sh1", tr_sh[1], 2'b00);

    // err_clr outside ERR has no effect
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("clr_idle_err",   bus.err, 0);
    chk("clr_idle_ready", bus.req_ready, 1);

    // Illegal request
    bus.req_valid = 1'b1;
    bus.req_state = 2'b11;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("ill_err",   bus.err, 1);
    chk("ill_ready", bus.req_ready, 0);
    chk("ill_ab",    {bus.a, bus.b}, 0);
    saw_done = bus.done;
    for (int i = 0; i < 3; i++) begin @(negedge clk); saw_done |= bus.done; end
    chk("ill_no_done", saw_done, 0);
    chk("ill_err_sticky", bus.err, 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("ill_clr_err",   bus.err, 0);
    chk("ill_clr_ready", bus.req_ready, 1);

    // Asynchronous reset in the middle of STEP1
    bus.req_valid = 1'b1;
    bus.req_state = 2'b01;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_step1_a", bus.a, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ab",     {bus.a, bus.b}, 0);
    chk("mid_rst_shadow", bus.shadow, 0);
    chk("mid_rst_done",   bus.done, 0);
    chk("mid_rst_err",    bus.err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", bus.req_ready, 1);

    // Target output disagreement while parked in s1
    request(2'b01, 2);
    @(negedge clk);
    force_y1_lo = 1'b1;
    @(negedge clk);
    force_y1_lo = 1'b0;
`ifdef MONITOR_EN
    chk("mon_err",   bus.err, 1);
    chk("mon_ab",    {bus.a, bus.b}, 0);
    chk("mon_ready", bus.req_ready, 0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("mon_clr_err", bus.err, 0);
`else
    chk("nomon_err",   bus.err, 0);
    chk("nomon_ready", bus.req_ready, 1);
`endif
    request(2'b00, 2);
    chk("recover_ab0", tr_ab[0], 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
